img_pixel_feeder: RTL

//  Raster-scan source stage placed directly upstream of the pixel adder.

---
 rtl/img_pixel_feeder_if.sv | 35 +++
 rtl/img_pixel_feeder.sv | 184 ++++++++++++++++++
 2 files changed

// File: rtl/img_pixel_feeder_if.sv
// Bundles the image-RAM read port and the pixel stream port of img_pixel_feeder.
// master: feeder side (drives RAM read strobe/address and pix_* outputs).
// slave : RAM/consumer side (returns RAM data, drives pix_ready).
interface img_pixel_feeder_if #(
  parameter int ADDR_W = 12,
  parameter int RBG_W  = 3
);
  logic              mem_rd_en;
  logic [ADDR_W-1:0] mem_addr;
  logic [RBG_W-1:0]  mem_rd_data;
  logic              pix_valid;
  logic              pix_ready;
  logic [RBG_W-1:0]  pix_rbg;
  logic [15:0]       pix_x;
  logic [15:0]       pix_y;
  logic              pix_sof;
  logic              pix_eol;
  logic              pix_eof;

  modport master (
    output mem_rd_en, mem_addr,
    input  mem_rd_data,
    output pix_valid,
    input  pix_ready,
    output pix_rbg, pix_x, pix_y, pix_sof, pix_eol, pix_eof
  );

  modport slave (
    input  mem_rd_en, mem_addr,
    output mem_rd_data,
    input  pix_valid,
    output pix_ready,
    input  pix_rbg, pix_x, pix_y, pix_sof, pix_eol, pix_eof
  );
endinterface

// File: rtl/img_pixel_feeder.sv
// Raster-scan pixel source: reads an IMG_W x IMG_H frame from a 1-cycle image RAM and streams it
// row-major with x/y and sof/eol/eof tags. start -> mem_rd_en after 1 cycle -> pix_valid after 3.
// Backpressure: a 2-entry buffer plus read credit; pix_* held stable while pix_valid && !pix_ready.
// Ports: clk, rst (sync, active-high), start, busy, done, bus (RAM read port + pixel stream).
// Optional IMG_FEED_LOOP_EN adds input 'loop': frames repeat back-to-back while it is high.
module img_pixel_feeder #(
  parameter int IMG_W  = 64,
  parameter int IMG_H  = 48,
  parameter int ADDR_W = 12,
  parameter int RBG_W  = 3
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
`ifdef IMG_FEED_LOOP_EN
  input  logic               loop,
`endif
  output logic               busy,
  output logic               done,
  img_pixel_feeder_if.master bus
);

  typedef enum logic [1:0] {IDLE, RUN, DRAIN} state_t;

  typedef struct packed {
    logic [RBG_W-1:0] rbg;
    logic [15:0]      x;
    logic [15:0]      y;
    logic             sof;
    logic             eol;
    logic             eof;
  } pix_t;

  localparam logic [15:0] X_LAST = 16'(IMG_W - 1);
  localparam logic [15:0] Y_LAST = 16'(IMG_H - 1);

  state_t            state_q, state_d;
  logic [15:0]       rd_x, rd_y;
  logic [ADDR_W-1:0] rd_addr;
  logic              rd_last;
  logic              rd_go;
  logic              inflight;
  logic [15:0]       tag_x, tag_y;
  logic              tag_sof, tag_eol, tag_eof;
  pix_t              in_pix, head, tail;
  logic [1:0]        fifo_cnt;
  logic              pix_valid, push, pop;
  logic              done_q;
  logic              loop_en;

`ifdef IMG_FEED_LOOP_EN
  assign loop_en = loop;
`else
  assign loop_en = 1'b0;
`endif

  assign rd_last   = (rd_x == X_LAST) && (rd_y == Y_LAST);
  assign pix_valid = (fifo_cnt != 2'd0);
  assign pop       = pix_valid && bus.pix_ready;
  assign push      = inflight;

  // State register
  always_ff @(posedge clk) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  // Next state. DRAIN only ends on the eof pixel that is also the last item outstanding, so an
  // earlier frame's eof still queued (tiny looped frames) cannot end the drain early.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (start) state_d = RUN;
      RUN:     if (rd_go && rd_last && !loop_en) state_d = DRAIN;
      DRAIN:   if (pop && head.eof && fifo_cnt == 2'd1 && !inflight) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Outputs. A read is issued only if the buffer can still take its data next cycle, counting
  // the read already in flight and the pop happening this cycle.
  always_comb begin
    busy  = (state_q != IDLE);
    rd_go = (state_q == RUN) &&
            (({1'b0, fifo_cnt} + {2'b00, inflight}) < (3'd2 + {2'b00, pop}));
  end

  // Read address/coordinate counters and the tag travelling with the in-flight read
  always_ff @(posedge clk) begin
    if (rst) begin
      rd_x     <= '0;
      rd_y     <= '0;
      rd_addr  <= '0;
      inflight <= 1'b0;
      tag_x    <= '0;
      tag_y    <= '0;
      tag_sof  <= 1'b0;
      tag_eol  <= 1'b0;
      tag_eof  <= 1'b0;
    end else begin
      inflight <= rd_go;
      if (rd_go) begin
        tag_x   <= rd_x;
        tag_y   <= rd_y;
        tag_sof <= (rd_x == 16'd0) && (rd_y == 16'd0);
        tag_eol <= (rd_x == X_LAST);
        tag_eof <= rd_last;
        if (rd_last) begin
          rd_x    <= '0;
          rd_y    <= '0;
          rd_addr <= '0;
        end else if (rd_x == X_LAST) begin
          rd_x    <= '0;
          rd_y    <= rd_y + 16'd1;
          rd_addr <= rd_addr + ADDR_W'(1);
        end else begin
          rd_x    <= rd_x + 16'd1;
          rd_addr <= rd_addr + ADDR_W'(1);
        end
      end
    end
  end

  always_comb begin
    in_pix     = '0;
    in_pix.rbg = bus.mem_rd_data;
    in_pix.x   = tag_x;
    in_pix.y   = tag_y;
    in_pix.sof = tag_sof;
    in_pix.eol = tag_eol;
    in_pix.eof = tag_eof;
  end

  // Two-entry shift buffer: head always feeds the outputs straight from flops.
  always_ff @(posedge clk) begin
    if (rst) begin
      fifo_cnt <= 2'd0;
      head     <= '0;
      tail     <= '0;
    end else begin
      case ({push, pop})
        2'b10: begin
          if (fifo_cnt == 2'd0) head <= in_pix;
          else                  tail <= in_pix;
          fifo_cnt <= fifo_cnt + 2'd1;
        end
        2'b01: begin
          head     <= tail;
          fifo_cnt <= fifo_cnt - 2'd1;
        end
        2'b11: begin
          if (fifo_cnt == 2'd1) begin
            head <= in_pix;
          end else begin
            head <= tail;
            tail <= in_pix;
          end
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) done_q <= 1'b0;
    else     done_q <= pop && head.eof;
  end

  assign done          = done_q;
  assign bus.mem_rd_en = rd_go;
  assign bus.mem_addr  = rd_addr;
  assign bus.pix_valid = pix_valid;
  assign bus.pix_rbg   = head.rbg;
  assign bus.pix_x     = head.x;
  assign bus.pix_y     = head.y;
  assign bus.pix_sof   = head.sof;
  assign bus.pix_eol   = head.eol;
  assign bus.pix_eof   = head.eof;

  // The read credit must make a push into a full buffer impossible.
  no_overflow: assert property (@(posedge clk) disable iff (rst)
                                !(push && !pop && fifo_cnt == 2'd2));

endmodule
